pim_encoder_acc: RTL and testbench

- Parametrised successor to the fixed 4-channel, 8-bit eFlash output encoder.
- Encodes N_CH channels of IN_W-bit eFlash sense outputs per read:
  - PARALLEL mode: popcount.
  - RBR mode: thermometer-to-binary.
- Accumulates a programmable number of reads per channel, then presents one result word per channel through a valid/ready handshake.
- Sits between the eFlash sense outputs and the output buffer.

---
 rtl/pim_encoder_acc_if.sv | 23 ++
 rtl/pim_encoder_acc.sv | 214 +++++++++++++++++++++
 tb/tb_pim_encoder_acc.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_encoder_acc_if.sv
// Streaming bus for pim_encoder_acc: eFlash read data in, per-channel results out.
// Both directions use a valid/ready handshake.
interface pim_encoder_acc_if #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 12
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [IN_W-1:0]  data_i [N_CH];
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ACC_W-1:0] acc_o [N_CH];

  modport master (
    output in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, acc_o
  );
  modport slave (
    input  in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, acc_o
  );
endinterface

// File: rtl/pim_encoder_acc.sv
// Multi-channel eFlash output encoder/accumulator (popcount or thermometer decode).
// Optional macro PIM_ENC_ACC_SAT_EN: saturating accumulate plus sticky sat_o flags.
module pim_enc_lane #(
  parameter int IN_W  = 8,
  parameter int ENC_W = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic             rbr_i,
  input  logic             clear_i,
  input  logic             acc_en_i,
  output logic [ACC_W-1:0] acc_o
`ifdef PIM_ENC_ACC_SAT_EN
  ,
  output logic             sat_o
`endif
);
`ifdef PIM_ENC_ACC_SAT_EN
  // Headroom for (acc<<1)+enc so the exact result can be compared to the max.
  localparam int SUM_W = ACC_W + ENC_W + 2;
  logic sat_d, sat_q;
`else
  localparam int SUM_W = ACC_W;
`endif

  logic [ENC_W-1:0] enc;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    enc = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (rbr_i) begin
        if (data_i[i]) enc = ENC_W'(i + 1);
      end else begin
        enc = enc + ENC_W'(data_i[i]);
      end
    end
  end

  always_comb begin
    sum   = rbr_i ? ((SUM_W'(acc_q) << 1) + SUM_W'(enc)) : (SUM_W'(acc_q) + SUM_W'(enc));
    acc_d = acc_q;
`ifdef PIM_ENC_ACC_SAT_EN
    sat_d = sat_q;
`endif
    if (clear_i) begin
      acc_d = '0;
`ifdef PIM_ENC_ACC_SAT_EN
      sat_d = 1'b0;
`endif
    end else if (acc_en_i) begin
`ifdef PIM_ENC_ACC_SAT_EN
      if (sat_q || (sum > SUM_W'({ACC_W{1'b1}}))) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
`ifdef PIM_ENC_ACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
`ifdef PIM_ENC_ACC_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign acc_o = acc_q;
`ifdef PIM_ENC_ACC_SAT_EN
  assign sat_o = sat_q;
`endif
endmodule

module pim_encoder_acc #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       pim_mode_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] acc_len_i,
  pim_encoder_acc_if.slave io,
  output logic             busy_o,
  output logic             err_o
`ifdef PIM_ENC_ACC_SAT_EN
  ,
  output logic [N_CH-1:0]  sat_o
`endif
);
  localparam int ENC_W = $clog2(IN_W + 1);
  localparam logic [2:0] MODE_PAR = 3'b101;
  localparam logic [2:0] MODE_RBR = 3'b110;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

  state_e           state_d, state_q;
  logic [LEN_W-1:0] len_d, len_q, cnt_d, cnt_q;
  logic             rbr_d, rbr_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             busy_d, busy_q;
  logic             err_d, err_q;
  logic             clear, accept;

  assign accept = in_ready_q & io.in_valid_i;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rbr_d       = rbr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (pim_mode_i == MODE_PAR || pim_mode_i == MODE_RBR) begin
            state_d    = ACCUM;
            rbr_d      = (pim_mode_i == MODE_RBR);
            len_d      = (acc_len_i == '0) ? LEN_W'(1) : acc_len_i;
            cnt_d      = '0;
            clear      = 1'b1;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          // len_q is at least 1 and at most 2^LEN_W-1, so cnt never wraps.
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d     = OUTPUT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (io.out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rbr_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rbr_q       <= rbr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign io.in_ready_o  = in_ready_q;
  assign io.out_valid_o = out_valid_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    pim_enc_lane #(.IN_W(IN_W), .ENC_W(ENC_W), .ACC_W(ACC_W)) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (io.data_i[c]),
      .rbr_i    (rbr_q),
      .clear_i  (clear),
      .acc_en_i (accept),
      .acc_o    (io.acc_o[c])
`ifdef PIM_ENC_ACC_SAT_EN
      ,
      .sat_o    (sat_o[c])
`endif
    );
  end
endmodule

// File: tb/tb_pim_encoder_acc.sv
// Randomized bench for pim_encoder_acc against a plain-arithmetic reference model.
module tb_pim_encoder_acc;
  localparam logic [2:0] PAR = 3'b101;
  localparam logic [2:0] RBR = 3'b110;
`ifdef PIM_ENC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT, default widths
  logic [2:0] mode_i = '0;
  logic       start  = 1'b0;
  logic [7:0] len_i  = '0;
  logic       busy, err;
  pim_encoder_acc_if #(.N_CH(4), .IN_W(8), .ACC_W(12)) bus ();

  // narrow-accumulator DUT for overflow behaviour
  logic [2:0] mode4  = '0;
  logic       start4 = 1'b0;
  logic [7:0] len4   = '0;
  logic       busy4, err4;
  pim_encoder_acc_if #(.N_CH(4), .IN_W(8), .ACC_W(4)) bus4 ();

`ifdef PIM_ENC_ACC_SAT_EN
  logic [3:0] sat, sat4;
`endif

  pim_encoder_acc #(.N_CH(4), .IN_W(8), .ACC_W(12), .LEN_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .pim_mode_i(mode_i), .start_i(start), .acc_len_i(len_i),
    .io(bus), .busy_o(busy), .err_o(err)
`ifdef PIM_ENC_ACC_SAT_EN
    , .sat_o(sat)
`endif
  );

  pim_encoder_acc #(.N_CH(4), .IN_W(8), .ACC_W(4), .LEN_W(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .pim_mode_i(mode4), .start_i(start4), .acc_len_i(len4),
    .io(bus4), .busy_o(busy4), .err_o(err4)
`ifdef PIM_ENC_ACC_SAT_EN
    , .sat_o(sat4)
`endif
  );

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] rd [256][4];
  int         exp_acc [4];
  bit         exp_sat [4];

  // Reference: encode each read from its definition and accumulate with integers.
  task automatic model(input bit rbr, input int n, input int accw);
    int a, x, e, dv, mx;
    bit s;
    mx = (1 << accw) - 1;
    for (int c = 0; c < 4; c++) begin
      a = 0; s = 0;
      for (int i = 0; i < n; i++) begin
        dv = int'(rd[i][c]);
        e  = rbr ? $clog2(dv + 1) : $countones(rd[i][c]);
        x  = rbr ? a * 2 + e : a + e;
        if (SAT) begin
          if (s || x > mx) begin a = mx; s = 1; end
          else a = x;
        end else begin
          a = x % (mx + 1);
        end
      end
      exp_acc[c] = a;
      exp_sat[c] = s;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 4; c++) rd[i][c] = 8'($urandom);
  endtask

  task automatic check_acc(input string tag);
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (int'(bus.acc_o[c]) !== exp_acc[c]) begin
        nerr++;
        $display("FAIL %s ch%0d acc_o got %0d want %0d", tag, c, bus.acc_o[c], exp_acc[c]);
      end
    end
  endtask

  // Runs one job on the main DUT using rd[0..]; holds out_ready low for 'hold' cycles.
  task automatic do_job(input logic [2:0] mode, input int len, input bit gap, input int hold);
    int  eff, i, cyc;
    bit  acc;
    eff = (len == 0) ? 1 : len;
    model(mode == RBR, eff, 12);
    @(posedge clk); #1;
    mode_i = mode; len_i = 8'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode_i = 3'($urandom); len_i = 8'($urandom);
    i = 0; cyc = 0;
    while (i < eff && cyc < 4 * eff + 20) begin
      bus.in_valid_i = gap ? (cyc % 2 == 1) : 1'b1;
      for (int c = 0; c < 4; c++) bus.data_i[c] = rd[i][c];
      @(negedge clk);
      acc = bus.in_valid_i && bus.in_ready_o;
      if (acc && i == eff - 1) begin
        nvec++;
        if (bus.out_valid_o !== 1'b0) begin
          nerr++; $display("FAIL valid_early got %b want 0", bus.out_valid_o);
        end
      end
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    nvec++;
    if (i != eff) begin nerr++; $display("FAIL accept_timeout got %0d reads want %0d", i, eff); end
    @(negedge clk);
    nvec++;
    if (bus.out_valid_o !== 1'b1) begin
      nerr++; $display("FAIL valid_latency got %b want 1", bus.out_valid_o);
    end
    check_acc("result");
`ifdef PIM_ENC_ACC_SAT_EN
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (sat[c] !== exp_sat[c]) begin
        nerr++; $display("FAIL sat ch%0d got %b want %b", c, sat[c], exp_sat[c]);
      end
    end
`endif
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (k == hold / 2) begin mode_i = PAR; len_i = 8'd1; start = 1'b1; end
      @(negedge clk);
      nvec++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
        nerr++;
        $display("FAIL hold valid/ready got %b/%b want 1/0", bus.out_valid_o, bus.in_ready_o);
      end
      check_acc("hold");
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL drain valid/busy got %b/%b want 0/0", bus.out_valid_o, busy);
    end
    check_acc("after_drain");
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL reset ctrl got rdy=%b vld=%b busy=%b err=%b want 0", bus.in_ready_o,
               bus.out_valid_o, busy, err);
    end
    for (int c = 0; c < 4; c++) exp_acc[c] = 0;
    check_acc("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_parallel();
    fill_random(3);
    rd[0][0] = 8'hFF; rd[1][0] = 8'h0F; rd[2][0] = 8'h01;
    do_job(PAR, 3, 1'b0, 0);
    nvec++;
    if (bus.acc_o[0] !== 12'd13) begin
      nerr++; $display("FAIL par_ch0 got %0d want 13", bus.acc_o[0]);
    end
  endtask

  task automatic test_rbr();
    fill_random(2);
    rd[0][1] = 8'b0000_0111; rd[1][1] = 8'b0001_1111;
    rd[0][2] = 8'b0100_0001; rd[1][2] = 8'h00;
    do_job(RBR, 2, 1'b0, 0);
    nvec++;
    if (bus.acc_o[1] !== 12'd11 || bus.acc_o[2] !== 12'd14) begin
      nerr++; $display("FAIL rbr ch1/ch2 got %0d/%0d want 11/14", bus.acc_o[1], bus.acc_o[2]);
    end
  endtask

  task automatic test_backpressure();
    int r0 [4];
    fill_random(6);
    do_job(RBR, 6, 1'b0, 0);
    for (int c = 0; c < 4; c++) r0[c] = int'(bus.acc_o[c]);
    do_job(RBR, 6, 1'b1, 5);
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (int'(bus.acc_o[c]) !== r0[c] || r0[c] !== exp_acc[c]) begin
        nerr++;
        $display("FAIL gapped ch%0d got %0d ungapped %0d want %0d", c, bus.acc_o[c], r0[c], exp_acc[c]);
      end
    end
  endtask

  task automatic test_invalid_mode();
    @(posedge clk); #1;
    mode_i = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL err_pulse got err=%b busy=%b want 1/0", err, busy);
    end
    @(posedge clk); #1;
    nvec++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL err_width got err=%b busy=%b want 0/0", err, busy);
    end
  endtask

  task automatic test_len_zero();
    fill_random(1);
    for (int c = 0; c < 4; c++) rd[0][c] = 8'hFF;
    do_job(PAR, 0, 1'b0, 0);
    nvec++;
    if (bus.acc_o[3] !== 12'd8) begin
      nerr++; $display("FAIL len0 got %0d want 8", bus.acc_o[3]);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      fill_random(12);
      do_job(($urandom_range(0, 1) == 1) ? RBR : PAR, $urandom_range(0, 12),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    fill_random(255);
    do_job(PAR, 255, 1'b0, 0);
  endtask

  task automatic test_overflow();
    int want;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 4; c++) rd[i][c] = 8'hFF;
    model(1'b0, 3, 4);
    want = SAT ? 15 : 8;
    @(posedge clk); #1;
    mode4 = PAR; len4 = 8'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    bus4.in_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) bus4.data_i[c] = 8'hFF;
    repeat (3) @(posedge clk);
    #1 bus4.in_valid_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus4.out_valid_o !== 1'b1) begin
      nerr++; $display("FAIL ovf_valid got %b want 1", bus4.out_valid_o);
    end
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (int'(bus4.acc_o[c]) !== want || want !== exp_acc[c]) begin
        nerr++; $display("FAIL ovf ch%0d got %0d want %0d", c, bus4.acc_o[c], want);
      end
`ifdef PIM_ENC_ACC_SAT_EN
      nvec++;
      if (sat4[c] !== 1'b1) begin
        nerr++; $display("FAIL ovf_sat ch%0d got %b want 1", c, sat4[c]);
      end
`endif
    end
    bus4.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready_i = 1'b0;
  endtask

  task automatic test_reset_midjob();
    fill_random(4);
    @(posedge clk); #1;
    mode_i = PAR; len_i = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) bus.data_i[c] = rd[i][c];
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++;
    if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL midreset got rdy=%b vld=%b busy=%b want 0", bus.in_ready_o, bus.out_valid_o, busy);
    end
    for (int c = 0; c < 4; c++) exp_acc[c] = 0;
    check_acc("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    do_job(PAR, 4, 1'b0, 0);
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus4.in_valid_i = 1'b0; bus4.out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin bus.data_i[c] = '0; bus4.data_i[c] = '0; end
    repeat (2) @(posedge clk);
    test_reset();
    test_parallel();
    test_rbr();
    test_backpressure();
    test_invalid_mode();
    test_len_zero();
    test_random();
    test_overflow();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
